// File: rtl/ram_b1_wr_seq.sv
// ram_b1_wr_seq: write-side sequencer for the layer-indexed beta storage of
// the SCAN polar decoder. Takes one (layer, node) command, collects the
// matching beta beats from the PE array and drives the storage write port,
// clearing the lanes the storage does not consume for that layer.
module ram_b1_wr_seq #(
  parameter int P = 64,
  parameter int Q = 6,
  parameter int N = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4:0]             cmd_layer,
  input  logic [$clog2(N)-2:0]   cmd_node,
  input  logic                   d_valid,
  output logic                   d_ready,
  input  logic [2*P*Q-1:0]       d_data,
  output logic [2*P*Q-1:0]       b_in,
  output logic [4:0]             layer_w,
  output logic [$clog2(N)-2:0]   w_address,
  output logic [3:0]             cnta,
  output logic                   w_en,
  output logic                   done,
  output logic                   err,
  output logic                   busy
);

  localparam int HalfW = P * Q;
  localparam int FullW = 2 * P * Q;

  typedef enum logic {IDLE, DATA} state_t;

  state_t                 state_q;
  logic [4:0]             layer_q;
  logic [$clog2(N)-2:0]   node_q;
  logic                   beat_q;
  logic [FullW-1:0]       bIn_q;
  logic [4:0]             layerW_q;
  logic [$clog2(N)-2:0]   wAddress_q;
  logic                   cnta_q;
  logic                   wEn_q;
  logic                   done_q;
  logic                   err_q;
  logic [FullW-1:0]       maskedData_d;
  logic                   lastBeat_d;
  logic                   layerLegal_d;

  // Lanes the storage keeps for a given layer: a prefix of the lower half
  // and a prefix of the upper half, everything else forced to zero.
  function automatic logic [FullW-1:0] keepMask(input logic [4:0] layer);
    logic [FullW-1:0] m;
    int lowW;
    int upW;
    m    = '0;
    lowW = 0;
    upW  = 0;
    case (layer)
      5'd8, 5'd7: begin lowW = HalfW;  upW = HalfW; end
      5'd6:       begin lowW = HalfW;  upW = 0;     end
      5'd2, 5'd3, 5'd4, 5'd5: begin
        lowW = Q << (int'(layer) - 1);
        upW  = lowW;
      end
      5'd1:       begin lowW = 2 * Q;  upW = 0;     end
      default:    begin lowW = 0;      upW = 0;     end
    endcase
    for (int i = 0; i < HalfW; i++) begin
      m[i]         = (i < lowW);
      m[i + HalfW] = (i < upW);
    end
    return m;
  endfunction

  // Beat masking, burst length and command legality from the latched/incoming fields.
  always_comb begin
    maskedData_d = d_data & keepMask(layer_q);
    lastBeat_d   = (layer_q == 5'd8) ? beat_q : 1'b1;
    layerLegal_d = (cmd_layer >= 5'd1) && (cmd_layer <= 5'd8);
  end

  // Command/beat FSM with the registered storage write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      node_q     <= '0;
      beat_q     <= 1'b0;
      bIn_q      <= '0;
      layerW_q   <= '0;
      wAddress_q <= '0;
      cnta_q     <= 1'b0;
      wEn_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wEn_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            layer_q <= cmd_layer;
            node_q  <= cmd_node;
            beat_q  <= 1'b0;
            if (layerLegal_d) begin
              state_q <= DATA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (d_valid) begin
            wEn_q      <= 1'b1;
            layerW_q   <= layer_q;
            wAddress_q <= node_q;
            cnta_q     <= beat_q;
            bIn_q      <= maskedData_d;
            if (lastBeat_d) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              beat_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshakes and status follow the state register; write port comes from registers.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    d_ready   = (state_q == DATA);
    busy      = (state_q == DATA);
    b_in      = bIn_q;
    layer_w   = layerW_q;
    w_address = wAddress_q;
    cnta      = {3'b000, cnta_q};
    w_en      = wEn_q;
    done      = done_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_ram_b1_wr_seq.sv
// tb_ram_b1_wr_seq: directed table-driven bench for ram_b1_wr_seq plus
// hand-written sequences for two-beat, illegal-layer and reset corner cases.
module tb_ram_b1_wr_seq;

  localparam int W = 768;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_layer;
  logic [8:0]    cmd_node;
  logic          d_valid;
  logic          d_ready;
  logic [W-1:0]  d_data;
  logic [W-1:0]  b_in;
  logic [4:0]    layer_w;
  logic [8:0]    w_address;
  logic [3:0]    cnta;
  logic          w_en;
  logic          done;
  logic          err;
  logic          busy;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [4:0]   layer;
    logic [8:0]   node;
    logic [W-1:0] data;
    logic [W-1:0] mask;
  } vec_t;

  vec_t vecs[10];

  logic [W-1:0] ones;
  logic [W-1:0] patA;
  logic [W-1:0] patB;
  logic [W-1:0] m1, m2, m3, m4, m5, m6;
  logic [W-1:0] lastB;

  ram_b1_wr_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_layer(cmd_layer), .cmd_node(cmd_node),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .b_in(b_in), .layer_w(layer_w), .w_address(w_address),
    .cnta(cnta), .w_en(w_en), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cv, input logic [4:0] l, input logic [8:0] n,
                               input logic dv, input logic [W-1:0] d);
    cmd_valid = cv;
    cmd_layer = l;
    cmd_node  = n;
    d_valid   = dv;
    d_data    = d;
  endtask

  task automatic runSingle(input vec_t v);
    logic [W-1:0] exp;
    exp = v.data & v.mask;
    applyStimulus(1'b1, v.layer, v.node, 1'b0, '0);
    tick();
    checkOutput("busy_after_cmd", busy, 1);
    checkOutput("cmd_ready_in_data", cmd_ready, 0);
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b1, v.data);
    tick();
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b0, '0);
    checkOutput("w_en", w_en, 1);
    checkOutput("done", done, 1);
    checkOutput("layer_w", layer_w, v.layer);
    checkOutput("w_address", w_address, v.node);
    checkOutput("cnta", cnta, 0);
    checkOutput("b_in", b_in, exp);
    checkOutput("busy_after_last", busy, 0);
    checkOutput("cmd_ready_after_last", cmd_ready, 1);
    tick();
    checkOutput("w_en_low", w_en, 0);
    checkOutput("done_low", done, 0);
    checkOutput("b_in_hold", b_in, exp);
  endtask

  initial begin
    ones = '1;
    patA = {96{8'hA5}};
    patB = {24{32'h1234_5678}};
    m1 = {{(W-12){1'b0}}, {12{1'b1}}};
    m2 = {{372{1'b0}}, {12{1'b1}}, {372{1'b0}}, {12{1'b1}}};
    m3 = {{360{1'b0}}, {24{1'b1}}, {360{1'b0}}, {24{1'b1}}};
    m4 = {{336{1'b0}}, {48{1'b1}}, {336{1'b0}}, {48{1'b1}}};
    m5 = {{288{1'b0}}, {96{1'b1}}, {288{1'b0}}, {96{1'b1}}};
    m6 = {{384{1'b0}}, {384{1'b1}}};

    vecs[0] = '{5'd7, 9'd3,   ones, ones};
    vecs[1] = '{5'd6, 9'd5,   ones, m6};
    vecs[2] = '{5'd1, 9'd0,   ones, m1};
    vecs[3] = '{5'd4, 9'd2,   ones, m4};
    vecs[4] = '{5'd2, 9'd17,  ones, m2};
    vecs[5] = '{5'd3, 9'd100, ones, m3};
    vecs[6] = '{5'd5, 9'd511, patA, m5};
    vecs[7] = '{5'd7, 9'd256, patB, ones};
    vecs[8] = '{5'd6, 9'd9,   patA, m6};
    vecs[9] = '{5'd1, 9'd1,   patB, m1};

    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_d_ready", d_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_w_en", w_en, 0);
    checkOutput("rst_b_in", b_in, 0);
    checkOutput("rst_cnta", cnta, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single-beat vector table");
    foreach (vecs[i]) runSingle(vecs[i]);

    $display("[TB] layer 8 two-beat write with gap");
    applyStimulus(1'b1, 5'd8, 9'd1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b1, patA);
    tick();
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b0, '0);
    checkOutput("l8_a_w_en", w_en, 1);
    checkOutput("l8_a_cnta", cnta, 0);
    checkOutput("l8_a_b_in", b_in, patA);
    checkOutput("l8_a_layer_w", layer_w, 8);
    checkOutput("l8_a_w_address", w_address, 1);
    checkOutput("l8_a_done", done, 0);
    checkOutput("l8_a_busy", busy, 1);
    for (int g = 0; g < 2; g++) begin
      tick();
      checkOutput("l8_gap_w_en", w_en, 0);
      checkOutput("l8_gap_busy", busy, 1);
      checkOutput("l8_gap_b_in_hold", b_in, patA);
    end
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b1, patB);
    tick();
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b0, '0);
    checkOutput("l8_b_w_en", w_en, 1);
    checkOutput("l8_b_cnta", cnta, 1);
    checkOutput("l8_b_b_in", b_in, patB);
    checkOutput("l8_b_done", done, 1);
    checkOutput("l8_b_busy", busy, 0);
    tick();
    checkOutput("l8_after_w_en", w_en, 0);

    $display("[TB] illegal layers");
    applyStimulus(1'b1, 5'd0, 9'd4, 1'b0, '0);
    tick();
    applyStimulus(1'b1, 5'd9, 9'd4, 1'b0, '0);
    checkOutput("ill0_err", err, 1);
    checkOutput("ill0_w_en", w_en, 0);
    checkOutput("ill0_busy", busy, 0);
    checkOutput("ill0_cmd_ready", cmd_ready, 1);
    checkOutput("ill0_done", done, 0);
    tick();
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b0, '0);
    checkOutput("ill9_err", err, 1);
    checkOutput("ill9_w_en", w_en, 0);
    checkOutput("ill9_busy", busy, 0);
    checkOutput("ill9_cmd_ready", cmd_ready, 1);
    tick();
    checkOutput("ill_err_low", err, 0);

    $display("[TB] command and beat together in IDLE");
    applyStimulus(1'b1, 5'd7, 9'd6, 1'b1, patB);
    tick();
    cmd_valid = 1'b0;
    checkOutput("simul_no_write", w_en, 0);
    checkOutput("simul_busy", busy, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b0, '0);
    checkOutput("simul_w_en", w_en, 1);
    checkOutput("simul_b_in", b_in, patB);
    checkOutput("simul_w_address", w_address, 6);
    checkOutput("simul_done", done, 1);
    tick();

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 5'd8, 9'd0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b1, ones);
    tick();
    applyStimulus(1'b0, 5'd0, 9'd0, 1'b0, '0);
    checkOutput("mid_w_en", w_en, 1);
    checkOutput("mid_done", done, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_w_en", w_en, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_cmd_ready", cmd_ready, 1);
    checkOutput("mid_rst_d_ready", d_ready, 0);
    checkOutput("mid_rst_b_in", b_in, 0);
    checkOutput("mid_rst_layer_w", layer_w, 0);
    checkOutput("mid_rst_w_address", w_address, 0);
    checkOutput("mid_rst_err", err, 0);
    d_valid = 1'b1;
    d_data  = ones;
    tick();
    d_valid = 1'b0;
    checkOutput("post_rst_no_write", w_en, 0);
    checkOutput("post_rst_no_done", done, 0);
    runSingle('{5'd7, 9'd2, ones, ones});

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
